// File: rtl/tlb_ctrl.sv
// TLB instruction controller: sequences SRCH/RD/WR/FILL/INV requests onto the
// TLB search, read and write ports and reports completion with a one-cycle pulse.
module tlb_ctrl #(
    parameter int TLBNUM = 16,
    localparam int IW = $clog2(TLBNUM)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [2:0]    req_op,
    input  logic [IW-1:0] req_index,
    input  logic [88:0]   req_entry,
    input  logic [4:0]    req_inv_op,
    output logic [18:0]   tlb_s_vppn,
    output logic [9:0]    tlb_s_asid,
    input  logic          tlb_s_found,
    input  logic [IW-1:0] tlb_s_index,
    output logic [IW-1:0] tlb_r_index,
    input  logic [88:0]   tlb_r_entry,
    output logic          tlb_we,
    output logic [IW-1:0] tlb_w_index,
    output logic [88:0]   tlb_w_entry,
    output logic          rsp_done,
    output logic          rsp_found,
    output logic [IW-1:0] rsp_index,
    output logic [88:0]   rsp_entry,
    output logic          rsp_err,
    output logic [2:0]    dbg_state
);
    localparam logic [2:0] OP_SRCH = 3'd0;
    localparam logic [2:0] OP_RD   = 3'd1;
    localparam logic [2:0] OP_WR   = 3'd2;
    localparam logic [2:0] OP_FILL = 3'd3;
    localparam logic [2:0] OP_INV  = 3'd4;
    localparam logic [IW-1:0] LAST = IW'(TLBNUM - 1);

    typedef enum logic [2:0] {S_IDLE, S_SRCH, S_RD, S_WR, S_INV, S_DONE} state_t;

    state_t        state;
    logic [IW-1:0] rnd;
    logic [IW-1:0] walk;
    logic [IW-1:0] q_index;
    logic [IW-1:0] q_widx;
    logic [88:0]   q_entry;
    logic [4:0]    q_inv_op;
    logic          inv_hit;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            rnd       <= '0;
            walk      <= '0;
            q_index   <= '0;
            q_widx    <= '0;
            q_entry   <= '0;
            q_inv_op  <= '0;
            rsp_done  <= 1'b0;
            rsp_found <= 1'b0;
            rsp_index <= '0;
            rsp_entry <= '0;
            rsp_err   <= 1'b0;
        end else begin
            rnd      <= (rnd == LAST) ? '0 : rnd + IW'(1);
            rsp_done <= 1'b0;
            rsp_err  <= 1'b0;
            case (state)
                S_IDLE: if (req_valid) begin
                    q_index  <= req_index;
                    q_entry  <= req_entry;
                    q_inv_op <= req_inv_op;
                    q_widx   <= (req_op == OP_FILL) ? rnd : req_index;
                    walk     <= '0;
                    case (req_op)
                        OP_SRCH:         state <= S_SRCH;
                        OP_RD:           state <= S_RD;
                        OP_WR, OP_FILL:  state <= S_WR;
                        OP_INV: begin
                            // An unknown invalidate code is rejected up front, no walk
                            if (req_inv_op > 5'd6) begin
                                state    <= S_DONE;
                                rsp_done <= 1'b1;
                                rsp_err  <= 1'b1;
                            end else begin
                                state <= S_INV;
                            end
                        end
                        default: begin
                            state    <= S_DONE;
                            rsp_done <= 1'b1;
                            rsp_err  <= 1'b1;
                        end
                    endcase
                end
                S_SRCH: begin
                    rsp_found <= tlb_s_found;
                    rsp_index <= tlb_s_index;
                    rsp_done  <= 1'b1;
                    state     <= S_DONE;
                end
                S_RD: begin
                    rsp_entry <= tlb_r_entry;
                    rsp_done  <= 1'b1;
                    state     <= S_DONE;
                end
                S_WR: begin
                    rsp_index <= q_widx;
                    rsp_done  <= 1'b1;
                    state     <= S_DONE;
                end
                S_INV: begin
                    if (walk == LAST) begin
                        rsp_done <= 1'b1;
                        state    <= S_DONE;
                    end else begin
                        walk <= walk + IW'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Invalidate match on the entry currently presented by the read port
    always_comb begin
        logic g;
        logic asid_eq;
        logic vppn_eq;
        g       = tlb_r_entry[52];
        asid_eq = (tlb_r_entry[62:53] == q_entry[62:53]);
        vppn_eq = (tlb_r_entry[68:63] == 6'd21) ? (tlb_r_entry[87:79] == q_entry[87:79])
                                                : (tlb_r_entry[87:69] == q_entry[87:69]);
        case (q_inv_op)
            5'd0, 5'd1: inv_hit = 1'b1;
            5'd2:       inv_hit = g;
            5'd3:       inv_hit = !g;
            5'd4:       inv_hit = !g && asid_eq;
            5'd5:       inv_hit = !g && asid_eq && vppn_eq;
            5'd6:       inv_hit = (g || asid_eq) && vppn_eq;
            default:    inv_hit = 1'b0;
        endcase
        inv_hit = inv_hit && tlb_r_entry[88];
    end

    assign req_ready   = (state == S_IDLE);
    assign tlb_s_vppn  = q_entry[87:69];
    assign tlb_s_asid  = q_entry[62:53];
    assign tlb_r_index = (state == S_INV) ? walk : q_index;
    assign tlb_we      = !reset && ((state == S_WR) || ((state == S_INV) && inv_hit));
    assign tlb_w_index = (state == S_INV) ? walk : q_widx;
    assign tlb_w_entry = (state == S_INV) ? {1'b0, tlb_r_entry[87:0]} : q_entry;
    assign dbg_state   = state;
endmodule

// File: tb/tb_tlb_ctrl.sv
// Bench for tlb_ctrl: a TLB array model answers the ports; a request-level model
// predicts per-cycle port activity and responses, checked every falling edge.
module tb_tlb_ctrl;
  localparam int TLBNUM = 16;
  localparam int IW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [2:0]    req_op = '0;
  logic [IW-1:0] req_index = '0;
  logic [88:0]   req_entry = '0;
  logic [4:0]    req_inv_op = '0;
  logic [18:0]   tlb_s_vppn;
  logic [9:0]    tlb_s_asid;
  logic          tlb_s_found;
  logic [IW-1:0] tlb_s_index;
  logic [IW-1:0] tlb_r_index;
  logic [88:0]   tlb_r_entry;
  logic          tlb_we;
  logic [IW-1:0] tlb_w_index;
  logic [88:0]   tlb_w_entry;
  logic          rsp_done;
  logic          rsp_found;
  logic [IW-1:0] rsp_index;
  logic [88:0]   rsp_entry;
  logic          rsp_err;
  logic [2:0]    dbg_state;

  tlb_ctrl #(.TLBNUM(TLBNUM)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_index(req_index), .req_entry(req_entry), .req_inv_op(req_inv_op),
    .tlb_s_vppn(tlb_s_vppn), .tlb_s_asid(tlb_s_asid), .tlb_s_found(tlb_s_found),
    .tlb_s_index(tlb_s_index), .tlb_r_index(tlb_r_index), .tlb_r_entry(tlb_r_entry),
    .tlb_we(tlb_we), .tlb_w_index(tlb_w_index), .tlb_w_entry(tlb_w_entry),
    .rsp_done(rsp_done), .rsp_found(rsp_found), .rsp_index(rsp_index),
    .rsp_entry(rsp_entry), .rsp_err(rsp_err), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  int tick = 0;
  int rel = 0;
  always @(posedge clk) tick++;

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [88:0] act, input logic [88:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- TLB array model (environment) ----------------
  logic [88:0] mem [TLBNUM];
  int wr_count = 0;

  function automatic bit vppn_match(input logic [88:0] ent, input logic [18:0] vppn);
    if (ent[68:63] == 6'd21) return (ent[87:69] >> 10) == (vppn >> 10);
    return ent[87:69] == vppn;
  endfunction

  function automatic bit tlb_hit(input logic [88:0] ent, input logic [18:0] vppn, input logic [9:0] asid);
    return ent[88] && vppn_match(ent, vppn) && (ent[52] || ent[62:53] == asid);
  endfunction

  always_comb begin
    tlb_s_found = 1'b0;
    tlb_s_index = '0;
    for (int i = TLBNUM - 1; i >= 0; i--)
      if (tlb_hit(mem[i], tlb_s_vppn, tlb_s_asid)) begin
        tlb_s_found = 1'b1;
        tlb_s_index = IW'(i);
      end
  end
  assign tlb_r_entry = mem[tlb_r_index];

  always @(posedge clk)
    if (tlb_we) begin
      mem[tlb_w_index] <= tlb_w_entry;
      wr_count <= wr_count + 1;
    end

  // ---------------- request-level reference model ----------------
  typedef struct packed {
    logic          ready, we, done, err, chk_s, chk_r;
    logic [IW-1:0] w_index, r_idx;
    logic [88:0]   w_entry;
    logic [18:0]   s_vppn;
    logic [9:0]    s_asid;
    logic          found;
    logic [IW-1:0] index;
    logic [88:0]   entry;
  } rec_t;

  rec_t          exp_q[$];
  logic [88:0]   ref_mem [TLBNUM];
  logic          mh_found = 1'b0;
  logic [IW-1:0] mh_index = '0;
  logic [88:0]   mh_entry = '0;

  function automatic bit inv_rule(input logic [4:0] op, input logic [88:0] ent,
                                  input logic [9:0] asid, input logic [18:0] vppn);
    bit g, aeq, veq;
    g = ent[52];
    aeq = (ent[62:53] == asid);
    veq = vppn_match(ent, vppn);
    if (!ent[88]) return 1'b0;
    case (op)
      5'd0, 5'd1: return 1'b1;
      5'd2: return g;
      5'd3: return !g;
      5'd4: return !g && aeq;
      5'd5: return !g && aeq && veq;
      5'd6: return (g || aeq) && veq;
      default: return 1'b0;
    endcase
  endfunction

  function automatic rec_t busy_rec();
    rec_t r;
    r = '0;
    r.found = mh_found;
    r.index = mh_index;
    r.entry = mh_entry;
    return r;
  endfunction

  task automatic predict(input logic [2:0] op, input logic [IW-1:0] idx,
                         input logic [88:0] ent, input logic [4:0] inv);
    rec_t r;
    r = busy_rec();
    r.ready = 1'b1;
    exp_q.push_back(r);
    if (op > 3'd4 || (op == 3'd4 && inv > 5'd6)) begin
      r = busy_rec(); r.done = 1'b1; r.err = 1'b1;
      exp_q.push_back(r);
      return;
    end
    r = busy_rec();
    case (op)
      3'd0: begin
        r.chk_s = 1'b1; r.s_vppn = ent[87:69]; r.s_asid = ent[62:53];
        exp_q.push_back(r);
        mh_found = 1'b0; mh_index = '0;
        for (int i = TLBNUM - 1; i >= 0; i--)
          if (tlb_hit(ref_mem[i], ent[87:69], ent[62:53])) begin
            mh_found = 1'b1; mh_index = IW'(i);
          end
      end
      3'd1: begin
        r.chk_r = 1'b1; r.r_idx = idx;
        exp_q.push_back(r);
        mh_entry = ref_mem[idx];
      end
      3'd2, 3'd3: begin
        r.we = 1'b1;
        r.w_index = (op == 3'd3) ? IW'((tick - rel) % TLBNUM) : idx;
        r.w_entry = ent;
        exp_q.push_back(r);
        mh_index = r.w_index;
      end
      default: begin
        for (int i = 0; i < TLBNUM; i++) begin
          r = busy_rec(); r.chk_r = 1'b1; r.r_idx = IW'(i);
          if (inv_rule(inv, ref_mem[i], ent[62:53], ent[87:69])) begin
            r.we = 1'b1; r.w_index = IW'(i);
            r.w_entry = ref_mem[i] & ~(89'd1 << 88);
          end
          exp_q.push_back(r);
        end
      end
    endcase
    r = busy_rec(); r.done = 1'b1;
    exp_q.push_back(r);
  endtask

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    rec_t r;
    if (reset) begin
      check("we_during_reset", tlb_we, 1'b0);
    end else begin
      if (exp_q.size() > 0) r = exp_q.pop_front();
      else begin r = busy_rec(); r.ready = 1'b1; end
      check("req_ready", req_ready, r.ready);
      check("tlb_we", tlb_we, r.we);
      check("rsp_done", rsp_done, r.done);
      check("rsp_err", rsp_err, r.err);
      check("rsp_found", rsp_found, r.found);
      check("rsp_index", rsp_index, r.index);
      check("rsp_entry", rsp_entry, r.entry);
      if (r.we) begin
        check("tlb_w_index", tlb_w_index, r.w_index);
        check("tlb_w_entry", tlb_w_entry, r.w_entry);
        ref_mem[r.w_index] = r.w_entry;
      end
      if (r.chk_s) begin
        check("tlb_s_vppn", tlb_s_vppn, r.s_vppn);
        check("tlb_s_asid", tlb_s_asid, r.s_asid);
      end
      if (r.chk_r) check("tlb_r_index", tlb_r_index, r.r_idx);
    end
  end

  // ---------------- driver tasks ----------------
  function automatic logic [88:0] mk(input logic e, input logic [18:0] vppn, input logic [5:0] ps,
                                     input logic [9:0] asid, input logic g, input logic [51:0] low);
    return {e, vppn, ps, asid, g, low};
  endfunction

  task automatic start_op(input logic [2:0] op, input logic [IW-1:0] idx,
                          input logic [88:0] ent, input logic [4:0] inv);
    req_valid = 1'b1; req_op = op; req_index = idx; req_entry = ent; req_inv_op = inv;
    predict(op, idx, ent, inv);
    @(posedge clk); #2;
    req_valid = 1'b0;
    req_op = 3'($urandom_range(0, 7));
    req_index = IW'($urandom_range(0, TLBNUM - 1));
    req_entry = {$urandom, $urandom, $urandom};
    req_inv_op = 5'($urandom_range(0, 31));
  endtask

  task automatic do_op(input logic [2:0] op, input logic [IW-1:0] idx,
                       input logic [88:0] ent, input logic [4:0] inv, output int lat);
    start_op(op, idx, ent, inv);
    lat = 1;
    while (1) begin
      @(negedge clk);
      if (rsp_done) break;
      lat++;
      if (lat > 40) break;
    end
    @(posedge clk); #2;
  endtask

  logic [88:0] ent_a, ent_b, ent_c, ent_d, ent_x, ent_e, ent_f;
  int lat, w0;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < TLBNUM; i++) begin mem[i] = '0; ref_mem[i] = '0; end
    ent_a = mk(1'b1, 19'h12345, 6'd12, 10'd5, 1'b0, 52'h00ABC_1111_2222);
    ent_b = mk(1'b1, 19'h12345, 6'd12, 10'd7, 1'b1, 52'h00DEF_3333_4444);
    ent_c = mk(1'b1, 19'h12A00, 6'd21, 10'd5, 1'b0, 52'h00123_5555_6666);
    ent_d = mk(1'b1, 19'h22000, 6'd21, 10'd3, 1'b1, 52'h00456_7777_8888);
    ent_x = mk(1'b1, 19'h07000, 6'd12, 10'd9, 1'b0, 52'h00789_9999_AAAA);
    ent_e = mk(1'b1, 19'h03333, 6'd12, 10'd1, 1'b0, 52'h00AAA_BBBB_CCCC);
    ent_f = mk(1'b1, 19'h04444, 6'd12, 10'd2, 1'b1, 52'h00BBB_DDDD_EEEE);

    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    rel = tick;

    // FILL with handshake six cycles after release lands at index 6
    repeat (6) @(posedge clk);
    #2;
    do_op(3'd3, 4'd0, ent_x, 5'd0, lat);
    check("fill_latency", lat, 2);
    check("fill_index_lit", rsp_index, 4'd6);
    check("fill_mem6_lit", mem[6], ent_x);

    do_op(3'd2, 4'd3, ent_a, 5'd0, lat);
    check("wr_latency", lat, 2);
    check("wr_mem3_lit", mem[3], ent_a);
    check("wr_err_lit", rsp_err, 1'b0);
    do_op(3'd2, 4'd4, ent_b, 5'd0, lat);
    do_op(3'd2, 4'd5, ent_c, 5'd0, lat);
    do_op(3'd2, 4'd7, ent_d, 5'd0, lat);

    do_op(3'd0, 4'd0, ent_a, 5'd0, lat);
    check("srch_latency", lat, 2);
    check("srch_found_lit", rsp_found, 1'b1);
    check("srch_index_lit", rsp_index, 4'd3);
    do_op(3'd0, 4'd0, mk(1'b0, 19'h00001, 6'd0, 10'd5, 1'b0, 52'd0), 5'd0, lat);
    check("srch_miss_lit", rsp_found, 1'b0);

    do_op(3'd1, 4'd6, '0, 5'd0, lat);
    check("rd_entry_lit", rsp_entry, ent_x);

    // INV op 5: only entry 3 qualifies (entry 4 is global)
    w0 = wr_count;
    do_op(3'd4, 4'd0, mk(1'b0, 19'h12345, 6'd0, 10'd5, 1'b0, 52'd0), 5'd5, lat);
    check("inv5_latency", lat, 17);
    check("inv5_writes_lit", wr_count - w0, 1);
    check("inv5_mem3_e_lit", mem[3][88], 1'b0);
    check("inv5_mem4_e_lit", mem[4][88], 1'b1);

    // INV op 2: global entries only, the 4MB non-global one survives
    w0 = wr_count;
    do_op(3'd4, 4'd0, '0, 5'd2, lat);
    check("inv2_writes_lit", wr_count - w0, 2);
    check("inv2_mem5_e_lit", mem[5][88], 1'b1);
    check("inv2_mem7_e_lit", mem[7][88], 1'b0);

    // INV op 6 matches the 4MB entry on vppn[18:10] only
    w0 = wr_count;
    do_op(3'd4, 4'd0, mk(1'b0, 19'h12A3F, 6'd0, 10'd5, 1'b0, 52'd0), 5'd6, lat);
    check("inv6_writes_lit", wr_count - w0, 1);
    check("inv6_mem5_e_lit", mem[5][88], 1'b0);

    w0 = wr_count;
    do_op(3'd7, 4'd2, ent_a, 5'd0, lat);
    check("illegal_latency", lat, 1);
    do_op(3'd4, 4'd0, '0, 5'd9, lat);
    check("badinv_latency", lat, 1);
    check("illegal_writes_lit", wr_count - w0, 0);

    // reset in the middle of an INV-all walk
    do_op(3'd2, 4'd3, ent_a, 5'd0, lat);
    do_op(3'd2, 4'd8, ent_f, 5'd0, lat);
    do_op(3'd2, 4'd10, ent_e, 5'd0, lat);
    w0 = wr_count;
    start_op(3'd4, 4'd0, '0, 5'd0);
    repeat (8) @(posedge clk);
    #2;
    exp_q.delete();
    reset = 1'b1;
    mh_found = 1'b0; mh_index = '0; mh_entry = '0;
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    rel = tick;
    @(negedge clk);
    check("ready_after_reset_lit", req_ready, 1'b1);
    repeat (20) @(posedge clk);
    #2;
    check("inv_reset_writes_lit", wr_count - w0, 2);
    check("inv_reset_mem8_lit", mem[8][88], 1'b1);
    check("inv_reset_mem10_lit", mem[10][88], 1'b1);

    do_op(3'd1, 4'd10, '0, 5'd0, lat);
    check("rd_after_reset_lit", rsp_entry, ent_e);
    repeat (3) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
